// File: rtl/bin_to_bcd_pipe.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per cycle.
// Saturates to all nines when the operand does not fit in DIGITS decimal digits.
module bin_to_bcd_pipe #(
    parameter int BIN_W      = 16,
    parameter int DIGITS     = 5,
    parameter int CONTINUOUS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_nz
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    function automatic logic [63:0] max_val(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_val(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [SW-1:0]     r_scratch;
    logic [SW-1:0]     w_adj;
    logic [CW-1:0]     r_cnt;
    logic              r_ovf_pend;
    logic              r_busy, r_done, r_overflow;
    logic [BW-1:0]     r_bcd;
    logic [DIGITS-1:0] r_nz;
    logic [BW-1:0]     w_res;
    logic [DIGITS-1:0] w_nz;
    logic              w_go, w_cnt_last, w_ovf_in, w_acc;

    assign w_go       = (CONTINUOUS != 0) || start;
    assign w_cnt_last = (r_cnt == CW'(BIN_W - 1));
    assign w_ovf_in   = ({{(64-BIN_W){1'b0}}, bin_in} > MAX_VAL);

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[BIN_W+4*i +: 4] >= 4'd5)
                w_adj[BIN_W+4*i +: 4] = r_scratch[BIN_W+4*i +: 4] + 4'd3;
        end
    end

    assign w_res = r_ovf_pend ? {DIGITS{4'h9}} : r_scratch[SW-1 -: BW];

    // Leading-zero mask: a digit is shown if it or any higher digit is nonzero.
    always_comb begin
        w_acc = 1'b0;
        w_nz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_acc   = w_acc | (|w_res[4*i +: 4]);
            w_nz[i] = w_acc;
        end
        w_nz[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_cnt_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_nz       <= DIGITS'(1);
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_scratch  <= SW'(bin_in);
                        r_cnt      <= '0;
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= {w_adj[SW-2:0], 1'b0};
                    r_cnt     <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_bcd      <= w_res;
                    r_overflow <= r_ovf_pend;
                    r_nz       <= w_nz;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_overflow;
    assign digit_nz = r_nz;

endmodule

// File: tb/tb_bin_to_bcd_pipe.sv
// Directed bench for bin_to_bcd_pipe across several parameter sets,
// with a division-based decimal model for the sweeps.
module tb_bin_to_bcd_pipe;

    logic clk, reset;

    logic [15:0] bin0;  logic start0, busy0, done0, ovf0;  logic [19:0] bcd0;  logic [4:0] nz0;
    logic [15:0] bin1;  logic start1, busy1, done1, ovf1;  logic [15:0] bcd1;  logic [3:0] nz1;
    logic [7:0]  bin2;  logic start2, busy2, done2, ovf2;  logic [11:0] bcd2;  logic [2:0] nz2;
    logic [19:0] bin3;  logic start3, busy3, done3, ovf3;  logic [23:0] bcd3;  logic [5:0] nz3;
    logic [0:0]  bin4;  logic start4, busy4, done4, ovf4;  logic [3:0]  bcd4;  logic [0:0] nz4;

    int n_vec = 0;
    int n_mis = 0;

    bin_to_bcd_pipe #(.BIN_W(16), .DIGITS(5), .CONTINUOUS(0)) u0 (
        .clk(clk), .reset(reset), .bin_in(bin0), .start(start0), .busy(busy0),
        .done(done0), .bcd_out(bcd0), .overflow(ovf0), .digit_nz(nz0));
    bin_to_bcd_pipe #(.BIN_W(16), .DIGITS(4), .CONTINUOUS(0)) u1 (
        .clk(clk), .reset(reset), .bin_in(bin1), .start(start1), .busy(busy1),
        .done(done1), .bcd_out(bcd1), .overflow(ovf1), .digit_nz(nz1));
    bin_to_bcd_pipe #(.BIN_W(8), .DIGITS(3), .CONTINUOUS(1)) u2 (
        .clk(clk), .reset(reset), .bin_in(bin2), .start(start2), .busy(busy2),
        .done(done2), .bcd_out(bcd2), .overflow(ovf2), .digit_nz(nz2));
    bin_to_bcd_pipe #(.BIN_W(20), .DIGITS(6), .CONTINUOUS(1)) u3 (
        .clk(clk), .reset(reset), .bin_in(bin3), .start(start3), .busy(busy3),
        .done(done3), .bcd_out(bcd3), .overflow(ovf3), .digit_nz(nz3));
    bin_to_bcd_pipe #(.BIN_W(1), .DIGITS(1), .CONTINUOUS(1)) u4 (
        .clk(clk), .reset(reset), .bin_in(bin4), .start(start4), .busy(busy4),
        .done(done4), .bcd_out(bcd4), .overflow(ovf4), .digit_nz(nz4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        longint unsigned m;
        longint unsigned x;
        logic [63:0] r;
        m = 1;
        x = v;
        r = '0;
        for (int i = 0; i < d; i++) m = m * 10;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = (v >= m) ? 4'd9 : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] get_done(input int w);
        case (w)
            0: return 64'(done0);
            1: return 64'(done1);
            2: return 64'(done2);
            3: return 64'(done3);
            default: return 64'(done4);
        endcase
    endfunction

    function automatic logic [63:0] get_busy(input int w);
        return (w == 0) ? 64'(busy0) : 64'(busy1);
    endfunction

    function automatic logic [63:0] get_bcd(input int w);
        return (w == 0) ? 64'(bcd0) : 64'(bcd1);
    endfunction

    function automatic logic [63:0] get_nz(input int w);
        return (w == 0) ? 64'(nz0) : 64'(nz1);
    endfunction

    function automatic logic [63:0] get_ovf(input int w);
        return (w == 0) ? 64'(ovf0) : 64'(ovf1);
    endfunction

    task automatic set_in(input int w, input logic [31:0] v, input logic s);
        if (w == 0) begin bin0 = v[15:0]; start0 = s; end
        else        begin bin1 = v[15:0]; start1 = s; end
    endtask

    task automatic wait_done(input int w, input int bound, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (get_done(w) !== 64'd1 && cyc < bound);
    endtask

    // Start pulse, then scramble bin_in while busy; result must reflect the captured value.
    task automatic conv(input int w, input logic [31:0] v, input logic [63:0] eb,
                        input logic [63:0] enz, input logic eo, input string tag);
        int cyc;
        @(negedge clk); set_in(w, v, 1'b1);
        @(posedge clk); #1;
        check({tag, "_busy"}, get_busy(w), 64'd1);
        @(negedge clk); set_in(w, ~v, 1'b0);
        wait_done(w, 40, cyc);
        check({tag, "_lat"}, 64'(cyc), 64'd17);
        check({tag, "_bcd"}, get_bcd(w), eb);
        check({tag, "_nz"}, get_nz(w), enz);
        check({tag, "_ovf"}, get_ovf(w), 64'(eo));
        check({tag, "_busy_lo"}, get_busy(w), 64'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, get_done(w), 64'd0);
    endtask

    initial begin
        int cyc, nd, first, nres;
        logic [15:0] f;
        logic [19:0] v3;
        logic [19:0] vals3 [0:5];
        logic [0:0]  vals4 [0:3];

        reset = 1'b1;
        bin0 = '0; start0 = 1'b0; bin1 = '0; start1 = 1'b0;
        bin2 = 8'd255; start2 = 1'b0; bin3 = '0; start3 = 1'b0;
        bin4 = 1'b0; start4 = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_bcd", 64'(bcd0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        check("rst_nz", 64'(nz0), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        conv(0, 65535, 64'h65535, 64'b11111, 1'b0, "d5_65535");
        conv(0, 0,     64'h00000, 64'b00001, 1'b0, "d5_0");
        conv(0, 407,   64'h00407, 64'b00111, 1'b0, "d5_407");
        conv(0, 12345, 64'h12345, 64'b11111, 1'b0, "d5_12345");
        conv(0, 100,   64'h00100, 64'b00111, 1'b0, "d5_100");
        conv(1, 9999,  64'h9999,  64'b1111,  1'b0, "d4_9999");
        conv(1, 10000, 64'h9999,  64'b1111,  1'b1, "d4_10000");
        conv(1, 42,    64'h0042,  64'b0011,  1'b0, "d4_42");

        // start toggling while busy: exactly one done
        @(negedge clk); bin0 = 16'd555; start0 = 1'b1;
        @(posedge clk); #1;
        nd = 0; first = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            start0 = (t < 16) ? 1'(t % 2) : 1'b0;
            bin0 = 16'(t * 3);
            @(posedge clk); #1;
            if (done0) begin
                nd++;
                if (first == 0) first = t;
            end
        end
        check("busy_pulses_ndone", 64'(nd), 64'd1);
        check("busy_pulses_when", 64'(first), 64'd17);
        check("busy_pulses_bcd", 64'(bcd0), 64'h00555);

        // start held high, bin_in changing every cycle
        nres = 0;
        for (int t = 0; t < 54; t++) begin
            @(negedge clk);
            bin0 = 16'(1000 + 37 * t);
            start0 = 1'b1;
            @(posedge clk); #1;
            if (done0) begin
                f = 16'(1000 + 37 * (18 * nres));
                check("b2b_time", 64'(t), 64'(18 * nres + 17));
                check("b2b_bcd", 64'(bcd0), ref_bcd(64'(f), 5));
                nres++;
            end
        end
        check("b2b_count", 64'(nres), 64'd3);
        @(negedge clk); start0 = 1'b0;

        // asynchronous reset mid-conversion
        @(negedge clk); bin0 = 16'd999; start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_bcd", 64'(bcd0), 64'd0);
        check("arst_busy", 64'(busy0), 64'd0);
        check("arst_ovf", 64'(ovf0), 64'd0);
        check("arst_nz", 64'(nz0), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_done", 64'(done0), 64'd0);
        end
        @(negedge clk); reset = 1'b1;
        conv(0, 4321, 64'h04321, 64'b01111, 1'b0, "post_rst");

        // continuous mode, BIN_W=8, DIGITS=3
        wait_done(2, 30, cyc);
        check("c8_first_seen", 64'(cyc < 30), 64'd1);
        for (int i = 0; i < 2; i++) begin
            wait_done(2, 30, cyc);
            check("c8_period", 64'(cyc), 64'd10);
            check("c8_bcd", 64'(bcd2), 64'h255);
            check("c8_nz", 64'(nz2), 64'b111);
        end
        bin2 = 8'd7;
        wait_done(2, 30, cyc);
        check("c8_period_7", 64'(cyc), 64'd10);
        check("c8_bcd_7", 64'(bcd2), 64'h007);
        check("c8_nz_7", 64'(nz2), 64'b001);

        // continuous sweep, BIN_W=20, DIGITS=6 (includes saturation)
        vals3[0] = 20'hFFFFF; vals3[1] = 20'd999999; vals3[2] = 20'd1000000;
        vals3[3] = 20'($urandom); vals3[4] = 20'($urandom); vals3[5] = 20'($urandom_range(0, 999));
        wait_done(3, 40, cyc);
        check("c20_first_seen", 64'(cyc < 40), 64'd1);
        for (int i = 0; i < 6; i++) begin
            v3 = vals3[i];
            bin3 = v3;
            wait_done(3, 40, cyc);
            check("c20_period", 64'(cyc), 64'd22);
            check("c20_bcd", 64'(bcd3), ref_bcd(64'(v3), 6));
            check("c20_ovf", 64'(ovf3), 64'(v3 > 20'd999999));
        end

        // continuous sweep, BIN_W=1, DIGITS=1
        vals4[0] = 1'b1; vals4[1] = 1'b0; vals4[2] = 1'b1; vals4[3] = 1'b1;
        wait_done(4, 10, cyc);
        check("c1_first_seen", 64'(cyc < 10), 64'd1);
        for (int i = 0; i < 4; i++) begin
            bin4 = vals4[i];
            wait_done(4, 10, cyc);
            check("c1_period", 64'(cyc), 64'd3);
            check("c1_bcd", 64'(bcd4), 64'(vals4[i]));
            check("c1_nz", 64'(nz4), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_pipe.md
BIN_TO_BCD_PIPE -- requirements
Module: bin_to_bcd_pipe

Parameters
REQ-001 SHALL provide BIN_W, default 16, binary input width (1..32).
REQ-002 SHALL provide DIGITS, default 5, number of BCD digits produced (1..10).
REQ-003 SHALL provide CONTINUOUS, default 0: 0 = convert on start only; 1 = free-running, restart automatically after every result.

Interface
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port bin_in  input  BIN_W  unsigned binary operand, sampled at capture only.
REQ-008 SHALL have port start  input  1  conversion request, level-sampled in IDLE; ignored when CONTINUOUS=1.
REQ-009 SHALL have port busy  output  1  high from the capture edge until the result edge.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high in the cycle after the result edge.
REQ-011 SHALL have port bcd_out  output  4*DIGITS  result, digit i at bits [4i+3:4i], held until the next result.
REQ-012 SHALL have port overflow  output  1  high when the held result came from an operand > 10^DIGITS-1.
REQ-013 SHALL have port digit_nz  output  DIGITS  leading-zero mask for display blanking.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 In IDLE, at an edge with start=1 (or always when CONTINUOUS=1), SHALL capture bin_in into the low BIN_W bits of a (4*DIGITS+BIN_W)-bit scratch register, upper bits 0, and go to SHIFT with counter=0 and busy=1.
REQ-016 SHALL also register an overflow flag at the capture edge, computed as bin_in > 10^DIGITS-1 (constant evaluated at elaboration, at least 36 bits wide).
REQ-017 Each SHIFT edge SHALL first add 3 to every BCD nibble >= 5, then shift scratch left by 1, then increment the counter.
REQ-018 SHALL leave SHIFT for DONE on the edge where the counter reaches BIN_W (exactly BIN_W shift edges).
REQ-019 On the DONE edge, SHALL latch bcd_out = upper 4*DIGITS scratch bits, or all nibbles 9 if overflow was flagged (saturate); latch overflow and digit_nz; set done=1 and busy=0; go to IDLE.
REQ-020 Latency: with capture at edge k, the result and done SHALL appear after edge k+BIN_W+1 (17 cycles at BIN_W=16).
REQ-021 Back-to-back: with start held high, the next capture SHALL occur at the edge after DONE, i.e. one result per BIN_W+2 cycles; CONTINUOUS=1 SHALL give the same cadence.
REQ-022 start while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in flight.
REQ-023 bin_in changes after the capture edge SHALL NOT affect the conversion in flight.
REQ-024 digit_nz[i] SHALL be 1 if digit i or any higher digit is nonzero; digit_nz[0] SHALL always be 1.
REQ-025 SHALL never emit a non-BCD nibble (A-F) on bcd_out.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, scratch=0, counter=0, busy=0, done=0, bcd_out=0, overflow=0, digit_nz = only bit 0 set.
REQ-027 reset asserted mid-conversion SHALL abort the conversion with no done pulse; bcd_out SHALL read 0.
REQ-028 After reset release, the first capture SHALL occur no earlier than the first rising edge with reset high.

Verification (BIN_W=16 unless stated)
REQ-029 DIGITS=5, start pulse with bin_in=65535 -> done 17 cycles after capture, bcd_out=0x65535, overflow=0, digit_nz=11111.
REQ-030 DIGITS=4, bin_in=9999 -> bcd_out=0x9999, overflow=0; then bin_in=10000 -> bcd_out=0x9999, overflow=1.
REQ-031 DIGITS=5, bin_in=0 -> bcd_out=0x00000, digit_nz=00001; bin_in=407 -> 0x00407, digit_nz=00111.
REQ-032 start held high with bin_in changing every cycle -> results exactly 18 cycles apart, each matching the bin_in sampled at its capture edge; pulses on start during busy produce no extra done.
REQ-033 reset pulsed low at shift cycle 8 -> outputs at reset values immediately (asynchronous), no done; the next start converts correctly.
REQ-034 CONTINUOUS=1, BIN_W=8, DIGITS=3, bin_in=255 static -> done every 10 cycles, bcd_out=0x255; random sweep checked against a reference model for BIN_W in {1,8,16,20}.
